// File: rtl/multicycle_ctrl.sv
// Moore main controller for the multicycle RV32I core: FETCH/DECODE/EXEC/MEM/WB sequencing, 3-5 cycles per instruction.
// MemReady=0 stalls FETCH, MEMREAD and MEMWRITE one cycle each; write enables are gated off while rst_n is low.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       op,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ImmSrc,
    output logic [2:0]       ALUControl,
    output logic             RegWrite,
    output logic             IllegalInstr,
    output logic [CNT_W-1:0] InstrCount
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_instr_count;

    logic       w_pcwrite;
    logic       w_adrsrc;
    logic       w_memwrite;
    logic       w_irwrite;
    logic [1:0] w_resultsrc;
    logic [1:0] w_alusrca;
    logic [1:0] w_alusrcb;
    logic [1:0] w_aluop;
    logic       w_regwrite;
    logic       w_illegal;
    logic       w_retire;
    logic [2:0] w_alucontrol;
    logic [1:0] w_immsrc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr_count <= '0;
        end else if (w_retire) begin
            r_instr_count <= r_instr_count + CNT_W'(1);
        end
    end

    always_comb begin
        w_next      = S_FETCH;
        w_pcwrite   = 1'b0;
        w_adrsrc    = 1'b0;
        w_memwrite  = 1'b0;
        w_irwrite   = 1'b0;
        w_resultsrc = 2'b00;
        w_alusrca   = 2'b00;
        w_alusrcb   = 2'b00;
        w_aluop     = 2'b00;
        w_regwrite  = 1'b0;
        w_illegal   = 1'b0;
        w_retire    = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_alusrcb   = 2'b10;
                w_resultsrc = 2'b10;
                w_irwrite   = MemReady;
                w_pcwrite   = MemReady;
                w_next      = MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                w_alusrca = 2'b01;
                w_alusrcb = 2'b01;
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXECR;
                    OP_I:         w_next = S_EXECI;
                    OP_JAL:       w_next = S_JAL;
                    OP_BEQ:       w_next = S_BEQ;
                    default: begin
                        w_next    = S_FETCH;
                        w_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                w_alusrca = 2'b10;
                w_alusrcb = 2'b01;
                w_next    = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_adrsrc = 1'b1;
                w_next   = MemReady ? S_MEMWB : S_MEMREAD;
            end
            S_MEMWB: begin
                w_resultsrc = 2'b01;
                w_regwrite  = 1'b1;
                w_retire    = 1'b1;
            end
            S_MEMWRITE: begin
                w_adrsrc   = 1'b1;
                w_memwrite = 1'b1;
                w_retire   = MemReady;
                w_next     = MemReady ? S_FETCH : S_MEMWRITE;
            end
            S_EXECR: begin
                w_alusrca = 2'b10;
                w_aluop   = 2'b10;
                w_next    = S_ALUWB;
            end
            S_EXECI: begin
                w_alusrca = 2'b10;
                w_alusrcb = 2'b01;
                w_aluop   = 2'b10;
                w_next    = S_ALUWB;
            end
            S_ALUWB: begin
                w_regwrite = 1'b1;
                w_retire   = 1'b1;
            end
            S_JAL: begin
                w_alusrca = 2'b01;
                w_alusrcb = 2'b10;
                w_pcwrite = 1'b1;
                w_next    = S_ALUWB;
            end
            S_BEQ: begin
                w_alusrca = 2'b10;
                w_aluop   = 2'b01;
                w_pcwrite = Zero;
                w_retire  = 1'b1;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Subtract only for R-type (op[5]) with bit 30 set; addi ignores bit 30.
    always_comb begin
        w_alucontrol = 3'b000;
        case (w_aluop)
            2'b01: w_alucontrol = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  w_alucontrol = (op[5] & funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  w_alucontrol = 3'b101;
                    3'b110:  w_alucontrol = 3'b011;
                    3'b111:  w_alucontrol = 3'b010;
                    default: w_alucontrol = 3'b000;
                endcase
            end
            default: w_alucontrol = 3'b000;
        endcase
    end

    always_comb begin
        w_immsrc = 2'b00;
        case (op)
            OP_SW:   w_immsrc = 2'b01;
            OP_BEQ:  w_immsrc = 2'b10;
            OP_JAL:  w_immsrc = 2'b11;
            default: w_immsrc = 2'b00;
        endcase
    end

    assign PCWrite      = rst_n & w_pcwrite;
    assign IRWrite      = rst_n & w_irwrite;
    assign MemWrite     = rst_n & w_memwrite;
    assign RegWrite     = rst_n & w_regwrite;
    assign IllegalInstr = rst_n & w_illegal;
    assign AdrSrc       = w_adrsrc;
    assign ResultSrc    = w_resultsrc;
    assign ALUSrcA      = w_alusrca;
    assign ALUSrcB      = w_alusrcb;
    assign ALUControl   = w_alucontrol;
    assign ImmSrc       = w_immsrc;
    assign InstrCount   = r_instr_count;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class cycle by cycle.
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst_n;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        Zero;
    logic        MemReady;
    logic        PCWrite;
    logic        AdrSrc;
    logic        MemWrite;
    logic        IRWrite;
    logic [1:0]  ResultSrc;
    logic [1:0]  ALUSrcA;
    logic [1:0]  ALUSrcB;
    logic [1:0]  ImmSrc;
    logic [2:0]  ALUControl;
    logic        RegWrite;
    logic        IllegalInstr;
    logic [31:0] InstrCount;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] exp_cnt;

    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(Zero), .MemReady(MemReady), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
        .ALUControl(ALUControl), .RegWrite(RegWrite),
        .IllegalInstr(IllegalInstr), .InstrCount(InstrCount)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no completion, wanted summary");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op = o; funct3 = f3; funct7b5 = f7;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; MemReady = 1'b1; Zero = 1'b0;
        set_instr(7'b0110011, 3'b000, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        n_chk++; if (IRWrite !== 1'b0) begin n_err++; $display("FAIL rst_irwrite: got %b want 0", IRWrite); end
        n_chk++; if (PCWrite !== 1'b0) begin n_err++; $display("FAIL rst_pcwrite: got %b want 0", PCWrite); end
        n_chk++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL rst_regwrite: got %b want 0", RegWrite); end
        n_chk++; if (MemWrite !== 1'b0) begin n_err++; $display("FAIL rst_memwrite: got %b want 0", MemWrite); end
        n_chk++; if (InstrCount !== 32'd0) begin n_err++; $display("FAIL rst_count: got %0d want 0", InstrCount); end
        n_chk++; if (ALUSrcB !== 2'b10) begin n_err++; $display("FAIL rst_alusrcb: got %b want 10", ALUSrcB); end
        rst_n = 1'b1;
        #1;
        n_chk++; if (IRWrite !== 1'b1) begin n_err++; $display("FAIL rel_irwrite: got %b want 1", IRWrite); end
        n_chk++; if (ALUSrcB !== 2'b10) begin n_err++; $display("FAIL rel_alusrcb: got %b want 10", ALUSrcB); end
        n_chk++; if (ResultSrc !== 2'b10) begin n_err++; $display("FAIL rel_resultsrc: got %b want 10", ResultSrc); end
        n_chk++; if (AdrSrc !== 1'b0) begin n_err++; $display("FAIL rel_adrsrc: got %b want 0", AdrSrc); end
        exp_cnt = 32'd0;
    endtask

    task automatic test_rtype_sub();
        set_instr(7'b0110011, 3'b000, 1'b1); MemReady = 1'b1;
        #1;
        n_chk++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL sub_c1_regwrite: got %b want 0", RegWrite); end
        cyc();
        n_chk++; if (ALUSrcA !== 2'b01 || ALUSrcB !== 2'b01) begin n_err++; $display("FAIL sub_decode_src: got %b/%b want 01/01", ALUSrcA, ALUSrcB); end
        n_chk++; if (IRWrite !== 1'b0 || RegWrite !== 1'b0) begin n_err++; $display("FAIL sub_decode_we: got ir=%b rw=%b want 0/0", IRWrite, RegWrite); end
        cyc();
        n_chk++; if (ALUControl !== 3'b001) begin n_err++; $display("FAIL sub_execr_aluctl: got %b want 001", ALUControl); end
        n_chk++; if (ALUSrcA !== 2'b10 || ALUSrcB !== 2'b00) begin n_err++; $display("FAIL sub_execr_src: got %b/%b want 10/00", ALUSrcA, ALUSrcB); end
        n_chk++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL sub_execr_regwrite: got %b want 0", RegWrite); end
        cyc();
        n_chk++; if (RegWrite !== 1'b1 || ResultSrc !== 2'b00) begin n_err++; $display("FAIL sub_aluwb: got rw=%b rs=%b want 1/00", RegWrite, ResultSrc); end
        n_chk++; if (InstrCount !== exp_cnt) begin n_err++; $display("FAIL sub_aluwb_count: got %0d want %0d", InstrCount, exp_cnt); end
        cyc();
        exp_cnt++;
        n_chk++; if (InstrCount !== exp_cnt) begin n_err++; $display("FAIL sub_count: got %0d want %0d", InstrCount, exp_cnt); end
        n_chk++; if (IRWrite !== 1'b1 || RegWrite !== 1'b0) begin n_err++; $display("FAIL sub_refetch: got ir=%b rw=%b want 1/0", IRWrite, RegWrite); end
    endtask

    logic [6:0] t_op [7] = '{7'b0010011, 7'b0010011, 7'b0010011, 7'b0010011, 7'b0110011, 7'b0110011, 7'b0010011};
    logic [2:0] t_f3 [7] = '{3'b010, 3'b110, 3'b111, 3'b000, 3'b000, 3'b111, 3'b001};
    logic       t_f7 [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0] t_ctl[7] = '{3'b101, 3'b011, 3'b010, 3'b000, 3'b000, 3'b010, 3'b000};

    task automatic test_alu_decode();
        for (int i = 0; i < 7; i++) begin
            set_instr(t_op[i], t_f3[i], t_f7[i]); MemReady = 1'b1;
            #1;
            cyc();
            cyc();
            n_chk++; if (ALUControl !== t_ctl[i]) begin n_err++; $display("FAIL alu_dec_%0d: got %b want %b", i, ALUControl, t_ctl[i]); end
            n_chk++; if (ALUSrcB !== (t_op[i][5] ? 2'b00 : 2'b01)) begin n_err++; $display("FAIL alu_srcb_%0d: got %b want %b", i, ALUSrcB, (t_op[i][5] ? 2'b00 : 2'b01)); end
            cyc();
            n_chk++; if (RegWrite !== 1'b1) begin n_err++; $display("FAIL alu_wb_%0d: got %b want 1", i, RegWrite); end
            cyc();
            exp_cnt++;
            n_chk++; if (InstrCount !== exp_cnt) begin n_err++; $display("FAIL alu_count_%0d: got %0d want %0d", i, InstrCount, exp_cnt); end
        end
    endtask

    task automatic test_lw_stall();
        int rw_hits;
        int imm_bad;
        logic exp_adr;
        rw_hits = 0; imm_bad = 0;
        set_instr(7'b0000011, 3'b010, 1'b0);
        for (int c = 0; c < 7; c++) begin
            MemReady = (c == 3 || c == 4) ? 1'b0 : 1'b1;
            #1;
            if (RegWrite === 1'b1 && ResultSrc === 2'b01) rw_hits++;
            if (ImmSrc !== 2'b00) imm_bad++;
            exp_adr = (c >= 3 && c <= 5);
            n_chk++; if (AdrSrc !== exp_adr) begin n_err++; $display("FAIL lw_adrsrc_c%0d: got %b want %b", c, AdrSrc, exp_adr); end
            cyc();
        end
        MemReady = 1'b1;
        #1;
        n_chk++; if (rw_hits !== 1) begin n_err++; $display("FAIL lw_wb_once: got %0d writes want 1", rw_hits); end
        n_chk++; if (imm_bad !== 0) begin n_err++; $display("FAIL lw_immsrc: got %0d bad cycles want 0", imm_bad); end
        n_chk++; if (IRWrite !== 1'b1) begin n_err++; $display("FAIL lw_7cycle_refetch: got irwrite %b want 1", IRWrite); end
        exp_cnt++;
        n_chk++; if (InstrCount !== exp_cnt) begin n_err++; $display("FAIL lw_count: got %0d want %0d", InstrCount, exp_cnt); end
    endtask

    task automatic test_sw_beq();
        set_instr(7'b0100011, 3'b010, 1'b0); MemReady = 1'b1;
        #1;
        n_chk++; if (ImmSrc !== 2'b01) begin n_err++; $display("FAIL sw_immsrc: got %b want 01", ImmSrc); end
        cyc();
        cyc();
        n_chk++; if (ALUSrcA !== 2'b10 || ALUSrcB !== 2'b01 || MemWrite !== 1'b0) begin n_err++; $display("FAIL sw_memadr: got %b/%b mw=%b want 10/01 0", ALUSrcA, ALUSrcB, MemWrite); end
        cyc();
        MemReady = 1'b0; #1;
        n_chk++; if (MemWrite !== 1'b1 || AdrSrc !== 1'b1) begin n_err++; $display("FAIL sw_stall1: got mw=%b adr=%b want 1/1", MemWrite, AdrSrc); end
        cyc();
        MemReady = 1'b0; #1;
        n_chk++; if (MemWrite !== 1'b1) begin n_err++; $display("FAIL sw_stall2: got %b want 1", MemWrite); end
        cyc();
        MemReady = 1'b1; #1;
        n_chk++; if (MemWrite !== 1'b1) begin n_err++; $display("FAIL sw_ready: got %b want 1", MemWrite); end
        n_chk++; if (InstrCount !== exp_cnt) begin n_err++; $display("FAIL sw_precount: got %0d want %0d", InstrCount, exp_cnt); end
        cyc();
        exp_cnt++;
        n_chk++; if (MemWrite !== 1'b0 || IRWrite !== 1'b1) begin n_err++; $display("FAIL sw_after: got mw=%b ir=%b want 0/1", MemWrite, IRWrite); end
        n_chk++; if (InstrCount !== exp_cnt) begin n_err++; $display("FAIL sw_count: got %0d want %0d", InstrCount, exp_cnt); end

        set_instr(7'b1100011, 3'b000, 1'b0); Zero = 1'b0;
        #1;
        n_chk++; if (ImmSrc !== 2'b10) begin n_err++; $display("FAIL beq_immsrc: got %b want 10", ImmSrc); end
        cyc();
        cyc();
        n_chk++; if (ALUControl !== 3'b001) begin n_err++; $display("FAIL beq_aluctl: got %b want 001", ALUControl); end
        n_chk++; if (PCWrite !== 1'b0) begin n_err++; $display("FAIL beq_nottaken: got %b want 0", PCWrite); end
        Zero = 1'b1; #1;
        n_chk++; if (PCWrite !== 1'b1 || RegWrite !== 1'b0) begin n_err++; $display("FAIL beq_taken: got pcw=%b rw=%b want 1/0", PCWrite, RegWrite); end
        cyc();
        Zero = 1'b0;
        exp_cnt++;
        n_chk++; if (InstrCount !== exp_cnt || IRWrite !== 1'b1) begin n_err++; $display("FAIL beq_3cycle: got cnt=%0d ir=%b want %0d/1", InstrCount, IRWrite, exp_cnt); end
    endtask

    task automatic test_jal();
        set_instr(7'b1101111, 3'b000, 1'b0); MemReady = 1'b1;
        #1;
        n_chk++; if (ImmSrc !== 2'b11) begin n_err++; $display("FAIL jal_immsrc: got %b want 11", ImmSrc); end
        cyc();
        cyc();
        n_chk++; if (PCWrite !== 1'b1 || ALUSrcA !== 2'b01 || ALUSrcB !== 2'b10) begin n_err++; $display("FAIL jal_state: got pcw=%b a=%b b=%b want 1/01/10", PCWrite, ALUSrcA, ALUSrcB); end
        n_chk++; if (RegWrite !== 1'b0) begin n_err++; $display("FAIL jal_rw: got %b want 0", RegWrite); end
        cyc();
        n_chk++; if (RegWrite !== 1'b1 || ResultSrc !== 2'b00 || PCWrite !== 1'b0) begin n_err++; $display("FAIL jal_aluwb: got rw=%b rs=%b pcw=%b want 1/00/0", RegWrite, ResultSrc, PCWrite); end
        cyc();
        exp_cnt++;
        n_chk++; if (InstrCount !== exp_cnt || IRWrite !== 1'b1) begin n_err++; $display("FAIL jal_count: got cnt=%0d ir=%b want %0d/1", InstrCount, IRWrite, exp_cnt); end
    endtask

    task automatic test_illegal();
        set_instr(7'b0000000, 3'b000, 1'b0); MemReady = 1'b1;
        #1;
        n_chk++; if (IllegalInstr !== 1'b0) begin n_err++; $display("FAIL ill_fetch: got %b want 0", IllegalInstr); end
        cyc();
        n_chk++; if (IllegalInstr !== 1'b1) begin n_err++; $display("FAIL ill_pulse: got %b want 1", IllegalInstr); end
        cyc();
        n_chk++; if (IllegalInstr !== 1'b0 || IRWrite !== 1'b1) begin n_err++; $display("FAIL ill_refetch: got ill=%b ir=%b want 0/1", IllegalInstr, IRWrite); end
        n_chk++; if (InstrCount !== exp_cnt) begin n_err++; $display("FAIL ill_count: got %0d want %0d", InstrCount, exp_cnt); end
    endtask

    task automatic test_reset_mid_write();
        set_instr(7'b0100011, 3'b010, 1'b0); MemReady = 1'b1;
        #1;
        cyc();
        cyc();
        cyc();
        MemReady = 1'b0; #1;
        n_chk++; if (MemWrite !== 1'b1) begin n_err++; $display("FAIL rmw_pre: got %b want 1", MemWrite); end
        rst_n = 1'b0; #1;
        n_chk++; if (MemWrite !== 1'b0 || AdrSrc !== 1'b0) begin n_err++; $display("FAIL rmw_drop: got mw=%b adr=%b want 0/0", MemWrite, AdrSrc); end
        n_chk++; if (InstrCount !== 32'd0) begin n_err++; $display("FAIL rmw_count: got %0d want 0", InstrCount); end
        cyc();
        n_chk++; if (MemWrite !== 1'b0) begin n_err++; $display("FAIL rmw_hold: got %b want 0", MemWrite); end
        rst_n = 1'b1; MemReady = 1'b1; #1;
        n_chk++; if (IRWrite !== 1'b1 || ALUSrcB !== 2'b10) begin n_err++; $display("FAIL rmw_fetch: got ir=%b b=%b want 1/10", IRWrite, ALUSrcB); end
        cyc();
        n_chk++; if (ALUSrcA !== 2'b01 || IRWrite !== 1'b0) begin n_err++; $display("FAIL rmw_decode: got a=%b ir=%b want 01/0", ALUSrcA, IRWrite); end
    endtask

    initial begin
        test_reset();
        test_rtype_sub();
        test_alu_decode();
        test_lw_stall();
        test_sw_beq();
        test_jal();
        test_illegal();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore-style main controller for the multicycle RV32I core.
- Sequences each instruction through fetch, decode, execute, memory and writeback using a state machine.
- Drives the datapath mux selects, the write enables and ImmSrc for the immediate extender.
- Handles a memory-ready handshake and counts retired instructions.

Parameters:
CNT_W, 32, width of the retired-instruction counter InstrCount

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
op  input  7  Instr[6:0] from the instruction register
funct3  input  3  Instr[14:12]
funct7b5  input  1  Instr[30]
Zero  input  1  ALU zero flag
MemReady  input  1  memory handshake: access completes in the cycle it is high
PCWrite  output  1  PC register enable
AdrSrc  output  1  memory address select: 0=PC, 1=ALUOut
MemWrite  output  1  data memory write strobe
IRWrite  output  1  instruction register / OldPC enable
ResultSrc  output  2  result mux: 00=ALUOut, 01=Data, 10=ALUResult
ALUSrcA  output  2  ALU A select: 00=PC, 01=OldPC, 10=RD1
ALUSrcB  output  2  ALU B select: 00=WriteData, 01=ImmExt, 10=constant 4
ImmSrc  output  2  extender format: 00=I, 01=S, 10=B, 11=J
ALUControl  output  3  ALU operation: 000=add, 001=sub, 010=and, 011=or, 101=slt
RegWrite  output  1  register file write enable
IllegalInstr  output  1  one-cycle pulse when an unsupported opcode is decoded
InstrCount  output  CNT_W  number of retired instructions

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- While rst_n=0:
  - state=FETCH and InstrCount=0.
  - PCWrite, IRWrite, MemWrite, RegWrite and IllegalInstr are forced to 0.
  - All other outputs take their FETCH values.
- The first active edge after reset release executes FETCH.
- A reset asserted in any state aborts the instruction immediately; no partial write is issued after the assertion.
- Outputs are combinational from the current state and inputs. Any signal not listed for a state is 0.
- ImmSrc is decoded from op in every state: sw(0100011)=01, beq(1100011)=10, jal(1101111)=11, otherwise 00.
- ALUOp (internal): 00 gives add; 01 gives sub; 10 decodes funct3:
  - 000: sub if op[5]&funct7b5, else add
  - 010: slt
  - 110: or
  - 111: and
  - any other funct3: add
- Supported opcodes: lw 0000011, sw 0100011, R-type 0110011, I-ALU 0010011, beq 1100011, jal 1101111.
- States, outputs and transitions:
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, ALUOp=00. IRWrite=PCWrite=MemReady. Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00. Next state by opcode:
    - lw or sw -> MEMADR
    - R-type -> EXECR
    - I-ALU -> EXECI
    - jal -> JAL
    - beq -> BEQ
    - any other opcode -> FETCH, with IllegalInstr=1 for this cycle
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. lw -> MEMREAD; sw -> MEMWRITE.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Stays while MemReady=0; goes to MEMWB when MemReady=1.
  - MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00. MemWrite=1 is held until the cycle with MemReady=1, then -> FETCH.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCWrite=1 -> ALUWB.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00. PCWrite=Zero -> FETCH.
- Unreachable state encodings return to FETCH on the next clock edge.
- Instruction latency with MemReady tied to 1:
  - beq: 3 cycles
  - R-type, I-ALU, sw: 4 cycles
  - jal: 4 cycles
  - lw: 5 cycles
- Each MemReady=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- InstrCount increments by 1 on the clock edge leaving MEMWB, ALUWB, BEQ, or MEMWRITE with MemReady=1.
- InstrCount wraps modulo 2^CNT_W. Illegal instructions are not counted.

Test Plan:
- Reset: hold rst_n=0 with MemReady=1 -> IRWrite=PCWrite=RegWrite=MemWrite=0 and InstrCount=0. After release, the first cycle shows IRWrite=1, ALUSrcB=10, ResultSrc=10.
- R-type sub (op=0110011, funct3=000, funct7b5=1), MemReady=1 -> states FETCH, DECODE, EXECR, ALUWB. ALUControl=001 in EXECR; RegWrite=1 only in cycle 4; InstrCount goes 0->1.
- lw with MemReady=0 for 2 cycles in MEMREAD -> 7-cycle instruction; RegWrite with ResultSrc=01 occurs exactly once; ImmSrc=00 throughout.
- sw followed by beq: sw gives ImmSrc=01, MemWrite held high through the stall and dropping after the MemReady cycle. beq gives ImmSrc=10, ALUControl=001 in BEQ; Zero=1 gives PCWrite=1, Zero=0 gives PCWrite=0.
- jal (op=1101111) -> ImmSrc=11; in JAL, PCWrite=1 with ALUSrcA=01 and ALUSrcB=10; then ALUWB with RegWrite=1.
- Illegal op=0000000 -> DECODE goes to FETCH with a one-cycle IllegalInstr pulse and InstrCount unchanged. A separate case asserts rst_n=0 mid-MEMWRITE -> MemWrite drops to 0 immediately and the state restarts in FETCH.
